// File: rtl/bpu_pkg.sv
// bpu_pkg: shared branch-op encodings, counter states, BTB entry type and compare helper
package bpu_pkg;
  localparam int XLEN_MAX = 64;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;
  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [XLEN_MAX-1:0] target;
    logic                is_jump;
  } btb_entry_t;
  function automatic logic br_eval(input logic [2:0] op, input logic eq, input logic lt, input logic ltu);
    case (op)
      BR_BEQ:  return eq;
      BR_BNE:  return !eq;
      BR_BLT:  return lt;
      BR_BGE:  return !lt;
      BR_BLTU: return ltu;
      BR_BGEU: return !ltu;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer with combinational lookup and registered write
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_target,
  output logic            rd_jump,
  input  logic            we,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_jump
);
  localparam int IW = $clog2(DEPTH);
  btb_entry_t btb_q [DEPTH];
  btb_entry_t btb_d [DEPTH];
  btb_entry_t rd_e;
  always_comb begin
    rd_e      = btb_q[rd_pc[IW+1:2]];
    rd_hit    = rd_e.valid && (rd_e.tag == XLEN_MAX'(rd_pc >> (IW + 2)));
    rd_target = rd_e.target[XLEN-1:0];
    rd_jump   = rd_e.is_jump;
    btb_d     = btb_q;
    if (we) btb_d[wr_pc[IW+1:2]] = '{valid: 1'b1, tag: XLEN_MAX'(wr_pc >> (IW + 2)), target: XLEN_MAX'(wr_target), is_jump: wr_jump};
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) btb_q[i] <= '0;
    else btb_q <= btb_d;
  end
endmodule

// File: rtl/bpu.sv
// bpu: BHT+BTB branch predictor with resolve-stage redirect; BPU_PERF_CNT_EN enables perf counters
module bpu
  import bpu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] x_rs1,
  input  logic [XLEN-1:0] x_rs2,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_br,
  input  logic [2:0]      br_op,
  input  logic            ex_trap,
  input  logic [XLEN-1:0] csr_r_data,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [63:0]     perf_br_cnt,
  output logic [63:0]     perf_miss_cnt
);
  localparam int BIW = $clog2(BHT_DEPTH);
  logic [1:0]      bht_q [BHT_DEPTH];
  logic [1:0]      bht_d [BHT_DEPTH];
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            acc, br_taken, act_taken, mispredict, btb_we;
  logic [XLEN-1:0] act_target;
  logic [BIW-1:0]  ex_idx;
  logic            btb_hit, btb_jump;
  logic [XLEN-1:0] btb_target;
  bpu_btb #(.XLEN(XLEN), .DEPTH(BTB_DEPTH)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (if_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .rd_jump   (btb_jump),
    .we        (btb_we),
    .wr_pc     (ex_pc),
    .wr_target (act_target),
    .wr_jump   (ex_jal | ex_jalr)
  );
  always_comb begin
    pred_taken    = btb_hit && (btb_jump || bht_q[if_pc[BIW+1:2]] >= WT);
    pred_target   = pred_taken ? btb_target : if_pc + XLEN'(4);
    acc           = ex_valid && !redirect_q;
    br_taken      = br_eval(br_op, x_rs1 == x_rs2, $signed(x_rs1) < $signed(x_rs2), x_rs1 < x_rs2);
    act_taken     = ex_trap || ex_jal || ex_jalr || (ex_br && br_taken);
    act_target    = ex_trap ? csr_r_data
                  : ex_jalr ? (x_rs1 + ex_imm) & ~XLEN'(1)
                  : (ex_jal || (ex_br && br_taken)) ? ex_pc + ex_imm
                  : ex_pc + XLEN'(4);
    mispredict    = acc && (ex_trap || act_taken != ex_pred_taken || (act_taken && act_target != ex_pred_target));
    btb_we        = acc && !ex_trap && (ex_jal || ex_jalr || (ex_br && br_taken));
    redirect_d    = mispredict;
    redirect_pc_d = act_target;
    ex_idx        = ex_pc[BIW+1:2];
    bht_d         = bht_q;
    if (acc && ex_br)
      bht_d[ex_idx] = br_taken ? (bht_q[ex_idx] == ST ? ST : bht_q[ex_idx] + 2'd1)
                               : (bht_q[ex_idx] == SNT ? SNT : bht_q[ex_idx] - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= WNT;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      bht_q         <= bht_d;
    end
  end
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
`ifdef BPU_PERF_CNT_EN
  logic [63:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    br_cnt_d   = br_cnt_q + 64'((acc && (ex_jal || ex_jalr || ex_br)) ? 1 : 0);
    miss_cnt_d = miss_cnt_q + 64'(mispredict ? 1 : 0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign perf_br_cnt   = br_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_br_cnt   = '0;
  assign perf_miss_cnt = '0;
`endif
endmodule

// File: doc/bpu.md
BPU -- requirements
Module: bpu

Interface
REQ-001 SHALL have parameter XLEN, 64, datapath width of PC, operands and targets.
REQ-002 SHALL have parameter BHT_DEPTH, 64, number of 2-bit counters, power of 2, at least 4.
REQ-003 SHALL have parameter BTB_DEPTH, 16, number of direct-mapped BTB entries, power of 2, at least 2.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port if_pc  in  XLEN  fetch PC to predict.
REQ-007 SHALL have port pred_taken  out  1  fetch prediction, combinational from if_pc.
REQ-008 SHALL have port pred_target  out  XLEN  predicted next PC, which is if_pc+4 when not taken.
REQ-009 SHALL have port ex_valid  in  1  resolve-stage instruction valid and not stalled.
REQ-010 SHALL have port ex_pc  in  XLEN  PC of the resolving instruction.
REQ-011 SHALL have port ex_imm  in  XLEN  sign-extended immediate.
REQ-012 SHALL have port x_rs1  in  XLEN  rs1 operand.
REQ-013 SHALL have port x_rs2  in  XLEN  rs2 operand.
REQ-014 SHALL have port ex_jal  in  1  JAL.
REQ-015 SHALL have port ex_jalr  in  1  JALR.
REQ-016 SHALL have port ex_br  in  1  conditional branch.
REQ-017 SHALL have port br_op  in  3  RISC-V funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
REQ-018 SHALL have port ex_trap  in  1  ecall or mret, target taken from csr_r_data.
REQ-019 SHALL have port csr_r_data  in  XLEN  trap or return target.
REQ-020 SHALL have port ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
REQ-021 SHALL have port ex_pred_target  in  XLEN  predicted target carried down the pipe.
REQ-022 SHALL have port redirect  out  1  registered flush-and-redirect request.
REQ-023 SHALL have port redirect_pc  out  XLEN  correct next PC, valid while redirect is high.
REQ-024 SHALL have port perf_br_cnt  out  64  count of resolved control-transfer instructions.
REQ-025 SHALL have port perf_miss_cnt  out  64  count of redirects.

Function
REQ-026 SHALL compute actual taken and target as follows: JAL gives ex_pc+ex_imm; JALR gives (x_rs1+ex_imm)&~1; a branch that is taken per br_op (signed and unsigned compares) gives ex_pc+ex_imm; ex_trap gives csr_r_data; otherwise the result is ex_pc+4. All sums wrap modulo 2^XLEN.
REQ-027 SHALL assert mispredict when ex_valid is high and either actual taken differs from ex_pred_taken, or the instruction is taken and its target differs from ex_pred_target. ex_trap is always a mispredict.
REQ-028 SHALL register redirect and redirect_pc one cycle after mispredict; redirect is a single-cycle pulse per mispredict.
REQ-029 SHALL ignore ex_valid during any cycle in which redirect is high, because that instruction is wrong-path: no redirect, no table update, no count.
REQ-030 SHALL index the BHT with ex_pc[log2(BHT_DEPTH)+1:2]. On every resolved ex_br, the counter SHALL increment (saturating at 3) when taken and decrement (saturating at 0) when not taken.
REQ-031 SHALL give each BTB entry the fields valid, tag = remaining upper PC bits, target, and is_jump. JAL, JALR, and taken ex_br SHALL write the entry; ex_trap SHALL never write it.
REQ-032 SHALL predict taken when the BTB hits (valid and tag match) and either is_jump is set or the BHT counter is 2 or above; pred_target is then the BTB target.
REQ-033 SHALL register table writes, so a lookup in the same cycle as an update at the same index returns the old contents.
REQ-034 SHALL make a JALR whose actual target differs from the BTB target mispredict and overwrite that target.

Reset
REQ-035 SHALL on rst set redirect=0, redirect_pc=0, all BHT counters to 01 (weakly not-taken), all BTB valid bits to 0 and both perf counters to 0; reset mid-operation drops any pending redirect.

Configuration
REQ-036 SHALL, with BPU_PERF_CNT_EN defined, increment perf_br_cnt on each accepted ex_jal, ex_jalr or ex_br and perf_miss_cnt on each redirect, both wrapping at 2^64. Without it, both ports SHALL be tied to 0 and no counter registers are generated.

Structure
REQ-037 SHALL place the br_op encodings, counter constants (SNT=0, WNT=1, WT=2, ST=3) and the BTB entry struct in shared package bpu_pkg.
REQ-038 SHALL implement the BTB storage, lookup and write port as sub-module bpu_btb.

Verification
REQ-039 SHALL cover: BEQ at 0x8000_0000, x_rs1=x_rs2=5, ex_pred_taken=0, imm=0x40 -> next cycle redirect=1, redirect_pc=0x8000_0040, counter goes from 1 to 2.
REQ-040 SHALL cover: repeating the same BEQ with if_pc=0x8000_0000 -> pred_taken=1, pred_target=0x8000_0040, and no redirect when resolved as predicted.
REQ-041 SHALL cover: BLTU with x_rs1=0xFFFF_FFFF_FFFF_FFFF, x_rs2=1 -> not taken; BLT with the same operands -> taken.
REQ-042 SHALL cover: JALR with x_rs1=0x1001, imm=0 -> redirect_pc=0x1000; a back-to-back ex_valid in the redirect cycle produces no update and no count.
REQ-043 SHALL cover: ex_trap with csr_r_data=0x8000_0100 -> redirect_pc=0x8000_0100 and the BTB is unchanged.
REQ-044 SHALL cover: asserting rst in the same cycle as a mispredict -> redirect stays 0, and a lookup after reset gives pred_taken=0.
